chacha_xor_packer: RTL
======================

// Module: chacha_xor_packer
// PURPOSE
// - Downstream of the keystream byte serialiser. XORs each keystream byte with one plaintext byte.
// - Packs the resulting ciphertext bytes into 32-bit words for the Poly1305/output path.
// - Requests a new ChaCha20 block every 64 keystream bytes and tracks the 32-bit block counter.
// - On message end, discards the unused keystream of the current block so the serialiser restarts aligned.
// PARAMETERS
// - BLOCK_BYTES  64  keystream bytes per ChaCha20 block; power of 2, >=4
// - INIT_CTR     1   block counter value after reset / at message start (RFC 8439)
// PORTS
// - clk        in   1   clock
// - rst        in   1   reset: synchronous, active-high
// - ks_byte    in   8   keystream byte from serialiser
// - ks_valid   in   1   ks_byte valid
// - ks_ready   out  1   keystream byte consumed this cycle
// - pt_byte    in   8   plaintext byte
// - pt_valid   in   1   pt_byte valid
// - pt_last    in   1   pt_byte is final byte of message
// - pt_ready   out  1   plaintext byte consumed this cycle
// - ct_word    out  32  ciphertext word; first byte in [31:24]
// - ct_keep    out  4   byte enables; bit3 = [31:24]; contiguous from MSB
// - ct_valid   out  1   ct_word valid
// - ct_last    out  1   word holds final message byte
// - ct_ready   in   1   downstream accepts ct_word
// - block_req  out  1   1-cycle pulse: generate/load next keystream block
// - block_ctr  out  32  counter value for the block being requested
// - busy       out  1   state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; ks_ready, pt_ready, ct_valid, ct_last, block_req, busy = 0;
//   ct_word=0; ct_keep=0; block_ctr=INIT_CTR; byte and block counters cleared.
// - FSM states: IDLE, REQ, XOR, DRAIN.
//   - IDLE -> REQ when pt_valid=1.
//   - REQ: block_req=1 for exactly one cycle, then -> XOR.
//   - XOR: transfer when ks_valid & pt_valid & (!ct_valid | ct_ready).
//     - On a transfer: ks_ready = pt_ready = 1 in that same cycle (combinational).
//   - End of block: on the 64th transfer (ks_idx wraps to 0) without pt_last:
//     block_ctr += 1 (mod 2^32); -> REQ.
//   - Last byte: on a transfer with pt_last=1:
//     - if ks_idx = BLOCK_BYTES-1 -> IDLE, block_ctr <= INIT_CTR;
//     - else -> DRAIN.
//   - DRAIN: ks_ready = ks_valid; pt_ready = 0; discard bytes until ks_idx wraps;
//     then -> IDLE, block_ctr <= INIT_CTR.
// - Packing: pack_reg[31:0] plus pack_idx[1:0]; byte n of the word goes to bits [31-8n -: 8].
//   - Word complete when pack_idx = 3 or pt_last.
//   - Load output register next cycle: ct_valid=1; keep=1111, or partial for last
//     (1 byte -> 1000, 2 -> 1100, 3 -> 1110).
//   - Unused byte lanes of a partial word are 0.
// - Latency: last byte of a word transferred at cycle N -> ct_valid=1 at N+1.
// - Output handshake:
//   - ct_word, ct_keep, ct_last are held stable while ct_valid & !ct_ready.
//   - ct_valid drops on the accept cycle unless a new word loads that same cycle.
// - Back-pressure: byte transfers stall whenever ct_valid & !ct_ready.
//   - No byte is lost or duplicated.
//   - ks_idx never advances without a matching pt byte in XOR.
// - Simultaneous events:
//   - ct accept and new word load in the same cycle is legal: one-word throughput every 4 cycles.
//   - Block wrap and pt_last on the same byte: last takes priority, no block_req.
// - Reset mid-operation: partial word and pending ct dropped; ct_valid=0 the next cycle;
//   block_ctr=INIT_CTR.
// - Counter widths: ks_idx is $clog2(BLOCK_BYTES) bits, wraps naturally;
//   block_ctr 32-bit, wraps 0xFFFFFFFF -> 0 with no error.
// STRUCTURE
// - Shared package chacha_pkg:
//   - word_t (logic [31:0]), byte_t (logic [7:0]);
//   - BLOCK_BYTES and INIT_CTR defaults;
//   - xor_state_t enum {IDLE, REQ, XOR, DRAIN}.
// - One sub-module: chacha_word_packer. Byte-in/word-out with last + keep generation
//   and a 1-entry output register; valid/ready on both sides.
// - Top-level logic: FSM, ks_idx, block_ctr, XOR datapath.
// TESTING
// - 8-byte msg; pt=00..07, ks=0xFF every byte, ct_ready=1
//   -> ct FF FE FD FC, then FB FA F9 F8; keep=1111; ct_last on word 2;
//   56 ks bytes drained; one block_req.
// - 64-byte msg, ks=pt -> 16 words of 0; last has keep=1111, ct_last=1;
//   exactly one block_req; no DRAIN; block_ctr back to 1.
// - 70-byte msg -> two block_req pulses with block_ctr=1 then 2;
//   last word keep=1100; 58 ks bytes drained.
// - ct_ready held 0 for 10 cycles mid-word -> ct_word stable; ks_ready=pt_ready=0
//   while stalled; stream matches golden XOR.
// - 5-byte msg -> second word keep=1000, lanes [23:0]=0;
//   then rst in XOR after 2 bytes of a new msg -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types and defaults for the ChaCha20 keystream XOR / ciphertext packing path.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    localparam int unsigned DEFAULT_BLOCK_BYTES = 64;
    localparam logic [31:0] DEFAULT_INIT_CTR    = 32'd1;

    typedef enum logic [1:0] {IDLE, REQ, XOR, DRAIN} xor_state_t;

    // Byte enables for a word whose final byte sits in lane idx (MSB-first, contiguous).
    function automatic logic [3:0] keep_for(input logic [1:0] idx);
        return 4'(4'b1111 << (2'd3 - idx));
    endfunction

endpackage

// File: rtl/chacha_word_packer.sv
// Packs bytes MSB-first into 32-bit words with keep/last; one-entry output register.
module chacha_word_packer
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  byte_t      in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output word_t      out_word,
    output logic [3:0] out_keep,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    word_t      pack_q;
    word_t      merged;
    logic [1:0] idx_q;
    logic       xfer;
    logic       done;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign done     = (idx_q == 2'd3) || in_last;

    always_comb begin
        merged = pack_q | (word_t'(in_byte) << (5'd24 - {idx_q, 3'b000}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q    <= '0;
            idx_q     <= '0;
            out_word  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // Accept and reload can coincide, giving one word per four bytes.
            if (xfer && done) begin
                out_word  <= merged;
                out_keep  <= keep_for(idx_q);
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                if (done) begin
                    pack_q <= '0;
                    idx_q  <= '0;
                end else begin
                    pack_q <= merged;
                    idx_q  <= idx_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/chacha_xor_packer.sv
// XORs keystream with plaintext, requests ChaCha20 blocks and drains unused keystream at
// message end; ciphertext bytes are packed into 32-bit words.
module chacha_xor_packer
    import chacha_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
    parameter logic [31:0] INIT_CTR    = DEFAULT_INIT_CTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ks_byte,
    input  logic        ks_valid,
    output logic        ks_ready,
    input  logic [7:0]  pt_byte,
    input  logic        pt_valid,
    input  logic        pt_last,
    output logic        pt_ready,
    output logic [31:0] ct_word,
    output logic [3:0]  ct_keep,
    output logic        ct_valid,
    output logic        ct_last,
    input  logic        ct_ready,
    output logic        block_req,
    output logic [31:0] block_ctr,
    output logic        busy
);

    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    xor_state_t       state_q, state_d;
    logic [IDX_W-1:0] ks_idx_q, ks_idx_d;
    logic [31:0]      ctr_q, ctr_d;
    logic             pk_in_ready;
    logic             xfer;
    logic             drop;
    logic             at_end;

    assign at_end = (ks_idx_q == LAST_IDX);
    assign xfer   = (state_q == XOR) && ks_valid && pt_valid && pk_in_ready;
    assign drop   = (state_q == DRAIN) && ks_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ks_idx_q <= '0;
            ctr_q    <= INIT_CTR;
        end else begin
            state_q  <= state_d;
            ks_idx_q <= ks_idx_d;
            ctr_q    <= ctr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (pt_valid) state_d = REQ;
            REQ:   state_d = XOR;
            XOR: begin
                if (xfer) begin
                    if (pt_last) begin
                        state_d = at_end ? IDLE : DRAIN;
                    end else if (at_end) begin
                        state_d = REQ;
                    end
                end
            end
            DRAIN: if (drop && at_end) state_d = IDLE;
        endcase
    end

    // Last byte beats block wrap: the counter rewinds instead of advancing.
    always_comb begin
        ks_idx_d = ks_idx_q;
        ctr_d    = ctr_q;
        if (xfer || drop) begin
            ks_idx_d = ks_idx_q + IDX_W'(1);
        end
        if (at_end && ((xfer && pt_last) || drop)) begin
            ctr_d = INIT_CTR;
        end else if (at_end && xfer) begin
            ctr_d = ctr_q + 32'd1;
        end
    end

    always_comb begin
        ks_ready  = xfer || drop;
        pt_ready  = xfer;
        block_req = (state_q == REQ);
        busy      = (state_q != IDLE);
        block_ctr = ctr_q;
    end

    chacha_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (ks_byte ^ pt_byte),
        .in_valid  (xfer),
        .in_last   (pt_last),
        .in_ready  (pk_in_ready),
        .out_word  (ct_word),
        .out_keep  (ct_keep),
        .out_valid (ct_valid),
        .out_last  (ct_last),
        .out_ready (ct_ready)
    );

endmodule
